double_accumulator: RTL and testbench

DOUBLE_ACCUMULATOR -- requirements
Module: double_accumulator

---
 rtl/fp64_pkg.sv | 19 +
 rtl/double_accumulator_if.sv | 25 ++
 rtl/double_accumulator.sv | 112 +++++++++++
 tb/tb_double_accumulator.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp64_pkg.sv
// Shared definitions for the double-precision accumulate path: FSM state type,
// IEEE-754 binary64 constants and the default width of the term counter.
package fp64_pkg;

  localparam int COUNT_W_DEFAULT = 16;

  localparam logic [63:0] FP64_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [63:0] FP64_QNAN = 64'hFFF8_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_ISSUE,
    ST_WAIT_ADD,
    ST_DRAIN,
    ST_DONE
  } acc_state_e;

endpackage

// File: rtl/double_accumulator_if.sv
// Term stream plus adder request/response bundle between the accumulator
// (master) and its surroundings: term source and double_adder (slave).
interface double_accumulator_if;

  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;

  logic        add_compute;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [63:0] add_z;
  logic        add_complete;

  modport master (
    input  in_valid, in_data, add_z, add_complete,
    output in_ready, add_compute, add_a, add_b
  );

  modport slave (
    output in_valid, in_data, add_z, add_complete,
    input  in_ready, add_compute, add_a, add_b
  );

endinterface

// File: rtl/double_accumulator.sv
// Sums `length` binary64 terms by sequencing an external double_adder;
// operand bits are passed through untouched, so special values are the adder's concern.
module double_accumulator
  import fp64_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [COUNT_W-1:0]   length,
  double_accumulator_if.master acc_if,
  output logic [63:0]          sum,
  output logic                 done,
  output logic                 busy
);

  acc_state_e         state;
  logic [COUNT_W-1:0] remaining;
  logic [63:0]        acc;

  // NOTE: every register here, outputs included, is updated with <= in one
  // clocked block so all state changes on the same edge without ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all state is plain flops (no memory arrays), so everything gets
      // a defined asynchronous reset value.
      state              <= ST_IDLE;
      remaining          <= '0;
      acc                <= FP64_ZERO;
      sum                <= FP64_ZERO;
      done               <= 1'b0;
      busy               <= 1'b0;
      acc_if.in_ready    <= 1'b0;
      acc_if.add_compute <= 1'b0;
      acc_if.add_a       <= FP64_ZERO;
      acc_if.add_b       <= FP64_ZERO;
    end else if (clk_en) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= length;
            acc       <= FP64_ZERO;
            busy      <= 1'b1;
            if (length == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              sum   <= FP64_ZERO;
            end else begin
              state           <= ST_WAIT_IN;
              acc_if.in_ready <= 1'b1;
            end
          end
        end

        ST_WAIT_IN: begin
          if (acc_if.in_valid) begin
            acc_if.add_a       <= acc;
            acc_if.add_b       <= acc_if.in_data;
            acc_if.in_ready    <= 1'b0;
            acc_if.add_compute <= 1'b1;
            state              <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          acc_if.add_compute <= 1'b0;
          state              <= ST_WAIT_ADD;
        end

        // remaining is never zero here, so the decrement cannot wrap.
        ST_WAIT_ADD: begin
          if (acc_if.add_complete) begin
            acc       <= acc_if.add_z;
            remaining <= remaining - COUNT_W'(1);
            state     <= ST_DRAIN;
          end
        end

        // Wait for add_complete to fall so a held-high response is taken once.
        ST_DRAIN: begin
          if (!acc_if.add_complete) begin
            if (remaining == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              sum   <= acc;
            end else begin
              state           <= ST_WAIT_IN;
              acc_if.in_ready <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state              <= ST_IDLE;
          done               <= 1'b0;
          busy               <= 1'b0;
          acc_if.in_ready    <= 1'b0;
          acc_if.add_compute <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_double_accumulator.sv
// Directed bench for double_accumulator with a behavioural double_adder beside it;
// a narrow COUNT_W makes the all-ones length reachable in a short run.
module tb_double_accumulator;
  import fp64_pkg::*;

  localparam int TB_COUNT_W = 4;

  localparam logic [63:0] D_ONE   = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D_TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D_HALF  = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] D_3P5   = 64'h400C_0000_0000_0000;
  localparam logic [63:0] D_15    = 64'h402E_0000_0000_0000;
  localparam logic [63:0] D_NAN_T = 64'h7FF8_0000_0000_0000;

  logic                  clk    = 1'b0;
  logic                  rst_n  = 1'b0;
  logic                  clk_en = 1'b0;
  logic                  start  = 1'b0;
  logic [TB_COUNT_W-1:0] length = '0;
  logic [63:0]           sum;
  logic                  done;
  logic                  busy;

  double_accumulator_if acc_if ();

  double_accumulator #(.COUNT_W(TB_COUNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .start  (start),
    .length (length),
    .acc_if (acc_if.master),
    .sum    (sum),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_compute_seen = 0;
  int n_done_seen = 0;
  int adder_lat = 3;
  int adder_hold = 1;
  logic [63:0] terms [16];

  // Enabled-cycle pulse counters.
  always @(posedge clk) begin
    if (rst_n && clk_en) begin
      if (acc_if.add_compute) n_compute_seen++;
      if (done) n_done_seen++;
    end
  end

  function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
    if ((a[62:52] == 11'h7FF && a[51:0] != 52'd0) || (b[62:52] == 11'h7FF && b[51:0] != 52'd0))
      return FP64_QNAN;
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  // Behavioural adder: fixed latency, add_complete held for adder_hold cycles.
  logic [63:0] m_z;
  int          m_cnt;
  bit          m_pend;
  int          m_hold_left;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend              <= 1'b0;
      m_cnt               <= 0;
      m_z                 <= '0;
      m_hold_left         <= 0;
      acc_if.add_complete <= 1'b0;
      acc_if.add_z        <= '0;
    end else if (clk_en && acc_if.add_compute && !m_pend) begin
      m_pend <= 1'b1;
      m_cnt  <= adder_lat;
      m_z    <= fp_add(acc_if.add_a, acc_if.add_b);
    end else if (m_pend) begin
      if (m_cnt <= 1) begin
        m_pend              <= 1'b0;
        acc_if.add_complete <= 1'b1;
        acc_if.add_z        <= m_z;
        m_hold_left         <= adder_hold;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left <= m_hold_left - 1;
      if (m_hold_left == 1) acc_if.add_complete <= 1'b0;
    end
  end

  task automatic send_term(input logic [63:0] data, input int gap);
    bit acc_ok;
    acc_ok = 1'b0;
    repeat (gap) @(negedge clk);
    acc_if.in_valid = 1'b1;
    acc_if.in_data  = data;
    for (int i = 0; i < 200; i++) begin
      acc_ok = acc_if.in_ready && clk_en;
      @(negedge clk);
      if (acc_ok) break;
    end
    acc_if.in_valid = 1'b0;
    n_vec++;
    if (!acc_ok) begin
      n_err++;
      $display("FAIL term_accept: in_ready never seen, required within 200 cycles");
    end else if (acc_if.add_compute !== 1'b1 || acc_if.add_b !== data) begin
      n_err++;
      $display("FAIL term_issue: add_compute=%b add_b=%h, required 1 and %h",
               acc_if.add_compute, acc_if.add_b, data);
    end
  endtask

  task automatic run_accum(input int len, input int max_gap, input bit freeze_wait_add,
                           input bit start_while_busy, input bit freeze_done,
                           output logic [63:0] got, output int d_done, output int d_comp);
    int c0, d0;
    bit seen;
    logic [63:0] snap_a, snap_b;
    c0 = n_compute_seen;
    d0 = n_done_seen;
    got = '0;
    seen = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    length = TB_COUNT_W'(len);
    @(negedge clk);
    start  = 1'b0;
    length = '0;
    for (int t = 0; t < len; t++) begin
      send_term(terms[t], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
      if (start_while_busy && t == 0) begin
        start  = 1'b1;
        length = '1;
        @(negedge clk);
        start  = 1'b0;
        length = '0;
      end
      if (freeze_wait_add && t == 1) begin
        @(negedge clk);
        snap_a = acc_if.add_a;
        snap_b = acc_if.add_b;
        clk_en = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_vec++;
          if (busy !== 1'b1 || acc_if.in_ready !== 1'b0 || acc_if.add_compute !== 1'b0 ||
              done !== 1'b0 || acc_if.add_a !== snap_a || acc_if.add_b !== snap_b) begin
            n_err++;
            $display("FAIL freeze_wait_add: busy=%b in_ready=%b add_compute=%b done=%b add_a=%h add_b=%h, required 1 0 0 0 %h %h",
                     busy, acc_if.in_ready, acc_if.add_compute, done, acc_if.add_a, acc_if.add_b,
                     snap_a, snap_b);
          end
        end
        clk_en = 1'b1;
      end
    end
    for (int i = 0; i < 300 && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        got  = sum;
        if (freeze_done) begin
          clk_en = 1'b0;
          repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b1 || sum !== got) begin
              n_err++;
              $display("FAIL freeze_done: done=%b sum=%h, required 1 and %h", done, sum, got);
            end
          end
          clk_en = 1'b1;
        end
      end else begin
        @(negedge clk);
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_wait: done never seen, required within 300 cycles");
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse_end: done=%b busy=%b, required 0 0", done, busy);
    end
    d_done = n_done_seen - d0;
    d_comp = n_compute_seen - c0;
  endtask

  task automatic check_run(input string name, input logic [63:0] got, input logic [63:0] exp_sum,
                           input int d_done, input int d_comp, input int exp_comp);
    n_vec++;
    if (got !== exp_sum) begin
      n_err++;
      $display("FAIL %s_sum: got %h, required %h", name, got, exp_sum);
    end
    n_vec++;
    if (d_done != 1) begin
      n_err++;
      $display("FAIL %s_done_count: got %0d, required 1", name, d_done);
    end
    n_vec++;
    if (d_comp != exp_comp) begin
      n_err++;
      $display("FAIL %s_compute_count: got %0d, required %0d", name, d_comp, exp_comp);
    end
  endtask

  task automatic load_basic_terms();
    terms[0] = D_ONE;
    terms[1] = D_TWO;
    terms[2] = D_HALF;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 64'h0 || acc_if.in_ready !== 1'b0 ||
        acc_if.add_compute !== 1'b0 || acc_if.add_a !== 64'h0 || acc_if.add_b !== 64'h0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h in_ready=%b add_compute=%b add_a=%h add_b=%h, required all zero",
               busy, done, sum, acc_if.in_ready, acc_if.add_compute, acc_if.add_a, acc_if.add_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || acc_if.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b in_ready=%b, required 0 0", busy, acc_if.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [63:0] got;
    int dd, dc;
    adder_lat = 3;
    adder_hold = 1;
    load_basic_terms();
    run_accum(3, 0, 1'b0, 1'b0, 1'b0, got, dd, dc);
    check_run("basic", got, D_3P5, dd, dc, 3);
  endtask

  task automatic test_zero_length();
    int c0, d0;
    c0 = n_compute_seen;
    d0 = n_done_seen;
    @(negedge clk);
    start  = 1'b1;
    length = '0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1 || sum !== 64'h0) begin
      n_err++;
      $display("FAIL zero_len_done: done=%b busy=%b sum=%h, required 1 1 0", done, busy, sum);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_idle: done=%b busy=%b, required 0 0", done, busy);
    end
    n_vec++;
    if (n_compute_seen != c0 || n_done_seen - d0 != 1) begin
      n_err++;
      $display("FAIL zero_len_counts: compute=%0d done=%0d, required 0 and 1",
               n_compute_seen - c0, n_done_seen - d0);
    end
  endtask

  task automatic test_gaps_clk_en();
    logic [63:0] got;
    int dd, dc;
    adder_lat = 3;
    adder_hold = 6;
    load_basic_terms();
    run_accum(3, 4, 1'b1, 1'b0, 1'b1, got, dd, dc);
    check_run("gaps_clk_en", got, D_3P5, dd, dc, 3);
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    int d0, dd, dc;
    adder_lat = 3;
    adder_hold = 1;
    load_basic_terms();
    d0 = n_done_seen;
    @(negedge clk);
    start  = 1'b1;
    length = TB_COUNT_W'(3);
    @(negedge clk);
    start  = 1'b0;
    length = '0;
    send_term(D_ONE, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || acc_if.add_compute !== 1'b0 || sum !== 64'h0 || done !== 1'b0 ||
        acc_if.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b add_compute=%b sum=%h done=%b in_ready=%b, required 0 0 0 0 0",
               busy, acc_if.add_compute, sum, done, acc_if.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (n_done_seen != d0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: done pulses=%0d busy=%b, required 0 0", n_done_seen - d0, busy);
    end
    run_accum(3, 0, 1'b0, 1'b0, 1'b0, got, dd, dc);
    check_run("after_reset", got, D_3P5, dd, dc, 3);
  endtask

  task automatic test_held_complete();
    logic [63:0] got;
    int dd, dc;
    adder_lat = 2;
    adder_hold = 5;
    load_basic_terms();
    run_accum(3, 0, 1'b0, 1'b1, 1'b0, got, dd, dc);
    check_run("held_complete", got, D_3P5, dd, dc, 3);
  endtask

  task automatic test_nan();
    logic [63:0] got;
    int dd, dc;
    adder_lat = 1;
    adder_hold = 1;
    terms[0] = D_ONE;
    terms[1] = D_NAN_T;
    terms[2] = D_TWO;
    run_accum(3, 1, 1'b0, 1'b0, 1'b0, got, dd, dc);
    check_run("nan", got, 64'hFFF8_0000_0000_0000, dd, dc, 3);
  endtask

  task automatic test_max_length();
    logic [63:0] got;
    int dd, dc;
    adder_lat = 1;
    adder_hold = 1;
    for (int i = 0; i < 16; i++) terms[i] = D_ONE;
    run_accum(15, 0, 1'b0, 1'b0, 1'b0, got, dd, dc);
    check_run("max_length", got, D_15, dd, dc, 15);
  endtask

  initial begin
    acc_if.in_valid = 1'b0;
    acc_if.in_data  = '0;
    test_reset();
    test_basic();
    test_zero_length();
    test_gaps_clk_en();
    test_reset_mid();
    test_held_complete();
    test_nan();
    test_max_length();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
